// File: rtl/mult_pkg.sv
// Shared constants and types for the multiplier datapath and its BCD
// display converter.
package mult_pkg;

    localparam logic [3:0] SIGN_NEG = 4'b1010;
    localparam logic [3:0] SIGN_POS = 4'b1100;

    localparam int unsigned RESULT_W   = 14;
    localparam int unsigned BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a passed-through sign code and a one-cycle done pulse.
module bcd_converter
    import mult_pkg::*;
#(
    parameter int unsigned BIN_W  = RESULT_W,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic [3:0]            sign_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            sign_out
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int unsigned SR_W  = ACC_W + BIN_W;

    bcd_state_t          state_q;
    logic [BIN_W-1:0]    bin_q;
    logic [ACC_W-1:0]    acc_q;
    logic [3:0]          sign_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [ACC_W-1:0]    digits_q;
    logic [3:0]          sign_out_q;

    logic [ACC_W-1:0]    acc_adj;
    logic [SR_W-1:0]     shift_d;
    logic [ACC_W-1:0]    acc_d;
    logic [BIN_W-1:0]    bin_d;

    // Per-digit add-3 correction ahead of the shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        shift_d = {acc_adj, bin_q} << 1;
        acc_d   = shift_d[SR_W-1:BIN_W];
        bin_d   = shift_d[BIN_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            sign_q     <= SIGN_POS;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digits_q   <= '0;
            sign_out_q <= SIGN_POS;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin_in;
                        sign_q  <= sign_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Results become visible only here, never mid-conversion
                    digits_q   <= acc_q;
                    sign_out_q <= sign_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digits   = digits_q;
    assign sign_out = sign_out_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: expected {digits, sign} pushed at start,
// popped and compared on every done pulse.
module tb_bcd_converter;
    import mult_pkg::*;

    localparam int unsigned BIN_W  = RESULT_W;
    localparam int unsigned DIGITS = BCD_DIGITS;
    localparam int unsigned ACC_W  = 4 * DIGITS;

    logic               clk;
    logic               rst;
    logic               start;
    logic [BIN_W-1:0]   bin_in;
    logic [3:0]         sign_in;
    logic               busy;
    logic               done;
    logic [ACC_W-1:0]   digits;
    logic [3:0]         sign_out;

    int n_tests;
    int n_fail;
    int n_done;
    int n_expect_done;

    logic [ACC_W+3:0] sb_q[$];

    bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .sign_in  (sign_in),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .sign_out (sign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] to_bcd(input int unsigned v);
        logic [ACC_W-1:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(posedge clk) begin
        #1;
        if (!rst && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [ACC_W+3:0] e;
                e = sb_q.pop_front();
                check("digits", 32'(digits), 32'(e[ACC_W+3:4]));
                check("sign_out", 32'(sign_out), 32'(e[3:0]));
            end
        end
    end

    // Drive one start, then wait (bounded) for done; returns edges from E0 to
    // done visibility and the number of sampled cycles with busy high.
    task automatic run_conv(input int unsigned v, input logic [3:0] s,
                            output int lat, output int busy_cyc);
        bit seen;
        @(negedge clk);
        start   = 1'b1;
        bin_in  = BIN_W'(v);
        sign_in = s;
        sb_q.push_back({to_bcd(v), s});
        n_expect_done++;
        lat = 0;
        busy_cyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) seen = 1'b1;
            else lat++;
        end
        if (!seen) check("done_timeout", 32'(0), 32'(1));
        #2;
    endtask

    initial begin
        int lat;
        int bc;
        int unsigned sweep[7];
        int unsigned v;
        bit got_done;

        n_tests = 0; n_fail = 0; n_done = 0; n_expect_done = 0;
        rst = 1'b1; start = 1'b0; bin_in = '0; sign_in = SIGN_POS;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_digits", 32'(digits), 32'(0));
        check("rst_sign", 32'(sign_out), 32'(SIGN_POS));
        @(negedge clk);
        rst = 1'b0;

        // Zero input: latency of 15 edges after start (done after E15)
        run_conv(0, SIGN_POS, lat, bc);
        check("latency_zero", 32'(lat), 32'(15));
        check("busy_cycles_zero", 32'(bc), 32'(15));

        run_conv(16129, SIGN_NEG, lat, bc);
        check("busy_cycles_16129", 32'(bc), 32'(15));
        check("digits_16129_direct", 32'(digits), 32'h16129);

        sweep = '{9, 10, 99, 100, 9999, 10000, 16383};
        foreach (sweep[i]) begin
            run_conv(sweep[i], (i % 2 == 0) ? SIGN_POS : SIGN_NEG, lat, bc);
            check("latency_sweep", 32'(lat), 32'(15));
        end

        // Extra start mid-SHIFT must be ignored
        @(negedge clk);
        start = 1'b1; bin_in = BIN_W'(777); sign_in = SIGN_NEG;
        sb_q.push_back({to_bcd(777), SIGN_NEG});
        n_expect_done++;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; bin_in = BIN_W'(42); sign_in = SIGN_POS;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("digits_after_ignored", 32'(digits), 32'h00777);
        check("sign_after_ignored", 32'(sign_out), 32'(SIGN_NEG));

        // Reset during the 7th SHIFT cycle of 12345
        @(negedge clk);
        start = 1'b1; bin_in = BIN_W'(12345); sign_in = SIGN_NEG;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("busy_before_rst", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_digits", 32'(digits), 32'(0));
        check("midrst_sign", 32'(sign_out), 32'(SIGN_POS));
        @(negedge clk);
        rst = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) got_done = 1'b1;
        end
        check("no_done_after_rst", 32'(got_done), 32'(0));
        run_conv(321, SIGN_POS, lat, bc);
        check("digits_321_direct", 32'(digits), 32'h00321);

        // Back-to-back random conversions
        for (int i = 0; i < 5; i++) begin
            v = $urandom_range(0, 16383);
            run_conv(v, ($urandom_range(0, 1) == 0) ? SIGN_POS : SIGN_NEG, lat, bc);
            check("latency_b2b", 32'(lat), 32'(15));
        end

        repeat (3) @(posedge clk);
        #2;
        check("done_count", 32'(n_done), 32'(n_expect_done));
        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
